alu_2bit_resp: RTL and testbench

Synthesizable responder end of the 2-bit ALU operand interface. It accepts {A, B, sel} requests on a valid/ready handshake and computes the 3-bit result. Results are returned in order on a valid/ready response channel through a small response FIFO. It sits between an operation initiator (sequencer or bench driver) and any result consumer.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_resp_fifo.sv | 44 ++++
 rtl/alu_2bit_resp.sv | 81 ++++++++
 tb/tb_alu_2bit_resp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and width helpers for the 2-bit ALU responder.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int ALU_WIDTH = 2;

    // Result carries one extra bit for carry/borrow.
    function automatic int res_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/alu_resp_fifo.sv
// Small synchronous FIFO holding ALU results; writes while full and reads while empty are dropped.
module alu_resp_fifo #(
    parameter int DW    = 3,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DEPTH-1:0][DW-1:0] mem;
    logic [AW-1:0]            wptr, rptr;
    logic                     full, do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop)
                rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/alu_2bit_resp.sv
// ALU responder: accepts {a, b, sel} requests and returns in-order results through a FIFO.
// Optional ALU_2BIT_RESP_STATS_EN adds saturating response/carry counters.
module alu_2bit_resp
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_result
`ifdef ALU_2BIT_RESP_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_carry
`endif
);

    localparam int RW = res_width(WIDTH);
    localparam int AW = $clog2(DEPTH);

    logic [RW-1:0] ea, eb, alu_res, fifo_rdata;
    logic [AW:0]   count;
    logic          empty;

    assign ea = {1'b0, req_a};
    assign eb = {1'b0, req_b};

    // Subtraction wraps modulo 2^RW so the MSB reads as the borrow.
    always_comb begin
        alu_res = '0;
        case (req_sel)
            OP_ADD:  alu_res = ea + eb;
            OP_SUB:  alu_res = ea - eb;
            OP_AND:  alu_res = ea & eb;
            OP_OR:   alu_res = ea | eb;
            default: alu_res = '0;
        endcase
    end

    assign req_ready = (count != (AW+1)'(DEPTH));

    alu_resp_fifo #(
        .DW    (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && req_ready),
        .pop   (rsp_ready),
        .wdata (alu_res),
        .rdata (fifo_rdata),
        .empty (empty),
        .count (count)
    );

    assign rsp_valid  = !empty;
    assign rsp_result = empty ? '0 : fifo_rdata;

`ifdef ALU_2BIT_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_carry <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (stat_ops != 16'hFFFF)
                stat_ops <= stat_ops + 16'd1;
            if (rsp_result[RW-1] && stat_carry != 16'hFFFF)
                stat_carry <= stat_carry + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_2bit_resp.sv
// Directed scoreboard bench for alu_2bit_resp; inputs driven and outputs sampled on the falling edge.
module tb_alu_2bit_resp;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready;
    logic [1:0] req_a, req_b, req_sel;
    logic       rsp_valid, rsp_ready;
    logic [2:0] rsp_result;
`ifdef ALU_2BIT_RESP_STATS_EN
    logic [15:0] stat_ops, stat_carry;
`endif

    int tests = 0;
    int fails = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    alu_2bit_resp #(.WIDTH(2), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result)
`ifdef ALU_2BIT_RESP_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_carry (stat_carry)
`endif
    );

    function automatic logic [2:0] model(input int a, input int b, input int sel);
        int r;
        case (sel)
            0:       r = a + b;
            1:       r = (a - b + 8) % 8;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return 3'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs settled: score the handshakes the next
    // rising edge will see, then advance to the following falling edge.
    task automatic cyc();
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", {29'd0, rsp_result}, 32'hDEAD);
                else                   chk("rsp_data", {29'd0, rsp_result}, {29'd0, exp_q.pop_front()});
            end
            if (req_valid && req_ready)
                exp_q.push_back(model(req_a, req_b, req_sel));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int a, input int b, input int sel);
        req_valid = 1'b1;
        req_a     = 2'(a);
        req_b     = 2'(b);
        req_sel   = 2'(sel);
    endtask

    // One isolated request with the consumer ready; result must appear one cycle later.
    task automatic send1(input int a, input int b, input int sel, input logic [2:0] lit);
        set_req(a, b, sel);
        chk("pre_ready", {31'd0, req_ready}, 32'd1);
        chk("pre_idle",  {31'd0, rsp_valid}, 32'd0);
        cyc();
        req_valid = 1'b0;
        chk("latency_vld", {31'd0, rsp_valid}, 32'd1);
        chk("literal_res", {29'd0, rsp_result}, {29'd0, lit});
        cyc();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while (exp_q.size() > 0 && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int idx, n;
        int ba[3], bb[3], bs[3];

        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b1;
        @(negedge clk);
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", {29'd0, rsp_result}, 32'd0);
        chk("rst_req_ready",  {31'd0, req_ready}, 32'd1);

        // basic ops
        send1(1, 2, 0, 3'b011);
        send1(3, 1, 1, 3'b010);
        send1(2, 1, 2, 3'b000);
        send1(2, 1, 3, 3'b011);
        // carry / borrow
        send1(3, 3, 0, 3'b110);
        send1(0, 1, 1, 3'b111);
        send1(1, 3, 1, 3'b110);
`ifdef ALU_2BIT_RESP_STATS_EN
        chk("stat_ops_7",   {16'd0, stat_ops}, 32'd7);
        chk("stat_carry_3", {16'd0, stat_carry}, 32'd3);
`endif

        // backpressure: third request must wait for the first pop
        ba = '{1, 3, 2}; bb = '{1, 2, 3}; bs = '{0, 1, 3};
        rsp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            set_req(ba[idx], bb[idx], bs[idx]);
            if (c >= 2) begin
                chk("full_ready",  {31'd0, req_ready}, 32'd0);
                chk("full_hold",   {29'd0, rsp_result}, {29'd0, model(1, 1, 0)});
            end
            acc = req_valid && req_ready;
            cyc();
            if (acc) idx++;
        end
        chk("bp_accepted2", idx, 2);
        rsp_ready = 1'b1;
        chk("full_pop_ready", {31'd0, req_ready}, 32'd0);
        cyc();
        chk("after_pop_ready", {31'd0, req_ready}, 32'd1);
        acc = req_valid && req_ready;
        cyc();
        if (acc) idx++;
        chk("bp_accepted3", idx, 3);
        drain("bp_drain");

        // streaming at count=1: one result every cycle
        set_req($urandom_range(3), $urandom_range(3), $urandom_range(3));
        cyc();
        for (int c = 0; c < 8; c++) begin
            set_req($urandom_range(3), $urandom_range(3), $urandom_range(3));
            chk("stream_vld",   {31'd0, rsp_valid}, 32'd1);
            chk("stream_ready", {31'd0, req_ready}, 32'd1);
            cyc();
        end
        drain("stream_drain");

        // reset with two results queued; request during rst is dropped
        rsp_ready = 1'b0;
        set_req(3, 3, 0); cyc();
        set_req(2, 2, 3); cyc();
        chk("preflush_full", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        set_req(1, 2, 0);
        cyc();
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("flush_vld",   {31'd0, rsp_valid}, 32'd0);
        chk("flush_res",   {29'd0, rsp_result}, 32'd0);
        chk("flush_ready", {31'd0, req_ready}, 32'd1);
        send1(1, 1, 0, 3'b010);

`ifdef ALU_2BIT_RESP_STATS_EN
        set_req(0, 0, 0);
        rsp_ready = 1'b1;
        n = 0;
        while (n < 65545) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        cyc(); cyc();
        exp_q.delete();
        chk("stat_ops_sat", {16'd0, stat_ops}, 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
